// File: rtl/serdes_word_aligner_pkg.sv
// Shared types for the SerDes word aligner: FSM state encoding,
// counter widths and the training-pattern mask helper.
package serdes_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERIFY,
        SLIP,
        WAIT,
        LOCKED,
        FAIL
    } align_state_t;

    localparam int SLIP_CNT_W  = 5;
    localparam int MATCH_CNT_W = 8;
    localparam int WAIT_CNT_W  = 4;
    localparam int PAT_W       = 10;

    // Keeps only the low 'width' bits of a 10-bit pattern.
    function automatic logic [PAT_W-1:0] pattern_mask(input int width);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/serdes_word_aligner_if.sv
// Bus between the I_SERDES side, the aligner and downstream fabric.
// slave: aligner view; master: the driver of SerDes-side inputs.
interface serdes_word_aligner_if
    import serdes_align_pkg::*;
#(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0]      data_i;
    logic                  data_valid_i;
    logic                  dpa_lock_i;
    logic                  realign_i;
    logic                  bitslip_o;
    logic [WIDTH-1:0]      data_o;
    logic                  data_valid_o;
    logic                  aligned_o;
    logic                  align_fail_o;
    logic [SLIP_CNT_W-1:0] slip_count_o;

    modport master (
        output data_i, data_valid_i, dpa_lock_i, realign_i,
        input  bitslip_o, data_o, data_valid_o,
        input  aligned_o, align_fail_o, slip_count_o
    );

    modport slave (
        input  data_i, data_valid_i, dpa_lock_i, realign_i,
        output bitslip_o, data_o, data_valid_o,
        output aligned_o, align_fail_o, slip_count_o
    );
endinterface

// File: rtl/serdes_word_aligner_counter.sv
// align_match_counter: clearable counter that saturates at TC.
// Ports: clk, reset, i_clr, i_inc in; o_tc high while count == TC.
module align_match_counter #(
    parameter int           W  = 8,
    parameter logic [W-1:0] TC = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && r_count != TC) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC);
endmodule

// File: rtl/serdes_word_aligner.sv
// Word aligner behind I_SERDES: pulses bitslip until training words
// match, then forwards payload. Ports: clk, reset, bus (slave).
module serdes_word_aligner
    import serdes_align_pkg::*;
#(
    parameter int         WIDTH         = 10,
    parameter logic [9:0] TRAIN_PATTERN = 10'h3E0,
    parameter int         SLIP_WAIT     = 4,
    parameter int         MATCH_COUNT   = 8,
    parameter int         MAX_SLIPS     = 2 * WIDTH
) (
    input logic                  clk,
    input logic                  reset,
    serdes_word_aligner_if.slave bus
);
    localparam logic [PAT_W-1:0] PAT_FULL =
        TRAIN_PATTERN & pattern_mask(WIDTH);
    localparam logic [WIDTH-1:0] PAT = PAT_FULL[WIDTH-1:0];
    localparam logic [SLIP_CNT_W-1:0] SLIP_MAX =
        SLIP_CNT_W'(MAX_SLIPS);
    // Counters flag the value one below target so the FSM can
    // move on the same edge the target is reached.
    localparam logic [MATCH_CNT_W-1:0] MATCH_TC =
        MATCH_CNT_W'(MATCH_COUNT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_TC =
        WAIT_CNT_W'(SLIP_WAIT - 1);

    align_state_t          r_state;
    align_state_t          w_next;
    logic                  r_bitslip;
    logic                  r_dv;
    logic                  r_aligned;
    logic                  r_fail;
    logic [WIDTH-1:0]      r_data;
    logic [SLIP_CNT_W-1:0] r_slip_cnt;

    logic w_match;
    logic w_match_tc;
    logic w_wait_tc;
    logic w_m_clr;
    logic w_m_inc;
    logic w_w_clr;
    logic w_w_inc;

    assign w_match = (bus.data_i == PAT);
    assign w_m_inc = (r_state == VERIFY) && bus.data_valid_i && w_match;
    assign w_m_clr = (r_state != VERIFY) ||
                     (bus.data_valid_i && !w_match);
    assign w_w_inc = (r_state == WAIT);
    assign w_w_clr = (r_state != WAIT);

    align_match_counter #(
        .W  (MATCH_CNT_W),
        .TC (MATCH_TC)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_m_clr),
        .i_inc (w_m_inc),
        .o_tc  (w_match_tc)
    );

    align_match_counter #(
        .W  (WAIT_CNT_W),
        .TC (WAIT_TC)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_w_clr),
        .i_inc (w_w_inc),
        .o_tc  (w_wait_tc)
    );

    always_comb begin
        w_next = r_state;
        if (r_state != IDLE && !bus.dpa_lock_i) begin
            w_next = IDLE;
        end else if (bus.realign_i) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.dpa_lock_i) w_next = VERIFY;
                end
                VERIFY: begin
                    if (bus.data_valid_i) begin
                        if (w_match) begin
                            if (w_match_tc) w_next = LOCKED;
                        end else if (r_slip_cnt >= SLIP_MAX) begin
                            w_next = FAIL;
                        end else begin
                            w_next = SLIP;
                        end
                    end
                end
                SLIP:    w_next = WAIT;
                WAIT: begin
                    if (w_wait_tc) w_next = VERIFY;
                end
                LOCKED:  w_next = LOCKED;
                FAIL:    w_next = FAIL;
                default: w_next = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so status flags
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bitslip  <= 1'b0;
            r_dv       <= 1'b0;
            r_aligned  <= 1'b0;
            r_fail     <= 1'b0;
            r_data     <= '0;
            r_slip_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_bitslip <= (w_next == SLIP);
            r_aligned <= (w_next == LOCKED);
            r_fail    <= (w_next == FAIL);
            if (r_state == LOCKED && w_next == LOCKED) begin
                r_data <= bus.data_i;
                r_dv   <= bus.data_valid_i;
            end else begin
                r_dv <= 1'b0;
            end
            if (w_next == SLIP && r_slip_cnt != SLIP_MAX) begin
                r_slip_cnt <= r_slip_cnt + 1'b1;
            end else if (r_state == IDLE && w_next == VERIFY) begin
                r_slip_cnt <= '0;
            end
        end
    end

    assign bus.bitslip_o    = r_bitslip;
    assign bus.data_o       = r_data;
    assign bus.data_valid_o = r_dv;
    assign bus.aligned_o    = r_aligned;
    assign bus.align_fail_o = r_fail;
    assign bus.slip_count_o = r_slip_cnt;
endmodule
